// File: rtl/dtw_cell_sequencer.sv
// -----------------------------------------------------------------------------
// dtw_cell_sequencer
//
// Walks the DTW cost matrix one cell at a time, row-major, over an
// (temp_len+1) x (test_len+1) run. For every cell it issues the template/test
// read addresses, the ping-pong row-memory addresses, and the cell-type code
// used by the comparator. Then it waits for the cell pipeline and pulses the
// write enable of the current-row memory. Cells do not overlap: the next cell
// is issued only after the previous cell's write, so reads never race writes.
//
// Handshake: start is a level sampled only in IDLE or DONE. busy is high from
// the cycle after start is accepted until the final cell is written. done rises
// as busy falls and stays high until the next accepted start or an abort.
// abort is sampled in every state and beats start and any pending write.
//
// Ports
//   clk                    system clock, rising edge
//   rst                    asynchronous active-low reset
//   start                  launch a run (IDLE/DONE only)
//   abort                  terminate the run, return to IDLE
//   temp_len               template length - 1 (rows), latched on start
//   test_len               test length - 1 (columns), latched on start
//   busy / done            run status
//   dtw_state              cell type: 0 idle, 1 origin, 2 first row,
//                          3 first column, 4 interior, 9 done
//   temp_mem_addr          row index i
//   test_mem_addr          column index j
//   even_addra/even_addrb  even row memory ports
//   odd_addra/odd_addrb    odd row memory ports
//   even/odd_mem_write_enable  write strobe for the current-row memory
//   result_sel             parity of the final row, valid while done=1
//   fsm_state_o            control FSM state, for debug visibility
// -----------------------------------------------------------------------------
module dtw_cell_sequencer #(
    parameter int PIPE_LAT = 3,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] temp_len,
    input  logic [ADDR_W-1:0] test_len,
    output logic              busy,
    output logic              done,
    output logic [3:0]        dtw_state,
    output logic [ADDR_W-1:0] temp_mem_addr,
    output logic [ADDR_W-1:0] test_mem_addr,
    output logic [ADDR_W-1:0] even_addra,
    output logic [ADDR_W-1:0] even_addrb,
    output logic [ADDR_W-1:0] odd_addra,
    output logic [ADDR_W-1:0] odd_addrb,
    output logic              even_mem_write_enable,
    output logic              odd_mem_write_enable,
    output logic              result_sel,
    output logic [2:0]        fsm_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] CT_IDLE      = 4'd0;
    localparam logic [3:0] CT_ORIGIN    = 4'd1;
    localparam logic [3:0] CT_FIRST_ROW = 4'd2;
    localparam logic [3:0] CT_FIRST_COL = 4'd3;
    localparam logic [3:0] CT_INTERIOR  = 4'd4;
    localparam logic [3:0] CT_DONE      = 4'd9;

    // WAIT lasts PIPE_LAT-1 cycles: the counter is loaded with PIPE_LAT-2 and
    // WRITE is entered when it reads zero.
    localparam logic [2:0] WAIT_LOAD = 3'(PIPE_LAT - 2);

    state_t            state_q;
    logic [ADDR_W-1:0] i_q;
    logic [ADDR_W-1:0] j_q;
    logic [ADDR_W-1:0] n_len_q;
    logic [ADDR_W-1:0] m_len_q;
    logic [2:0]        wait_q;

    // Next cell to issue: (0,0) on launch, the row-major successor after WRITE.
    logic              last_cell_d;
    logic [ADDR_W-1:0] i_d;
    logic [ADDR_W-1:0] j_d;
    logic [ADDR_W-1:0] jm1_d;
    logic [3:0]        type_d;

    always_comb begin
        last_cell_d = (i_q == n_len_q) && (j_q == m_len_q);
        i_d         = '0;
        j_d         = '0;
        if (state_q == S_WRITE) begin
            if (j_q != m_len_q) begin
                i_d = i_q;
                j_d = j_q + 1'b1;
            end else begin
                i_d = i_q + 1'b1;
                j_d = '0;
            end
        end
        // j-1 at column 0 is a don't-care for the comparator; drive 0.
        jm1_d = (j_d == '0) ? '0 : (j_d - 1'b1);
        if (i_d == '0 && j_d == '0) begin
            type_d = CT_ORIGIN;
        end else if (i_d == '0) begin
            type_d = CT_FIRST_ROW;
        end else if (j_d == '0) begin
            type_d = CT_FIRST_COL;
        end else begin
            type_d = CT_INTERIOR;
        end
    end

    assign fsm_state_o = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q               <= S_IDLE;
            i_q                   <= '0;
            j_q                   <= '0;
            n_len_q               <= '0;
            m_len_q               <= '0;
            wait_q                <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            dtw_state             <= CT_IDLE;
            temp_mem_addr         <= '0;
            test_mem_addr         <= '0;
            even_addra            <= '0;
            even_addrb            <= '0;
            odd_addra             <= '0;
            odd_addrb             <= '0;
            even_mem_write_enable <= 1'b0;
            odd_mem_write_enable  <= 1'b0;
            result_sel            <= 1'b0;
        end else if (abort) begin
            // Abort beats start and suppresses a write about to be strobed.
            state_q               <= S_IDLE;
            i_q                   <= '0;
            j_q                   <= '0;
            wait_q                <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            dtw_state             <= CT_IDLE;
            temp_mem_addr         <= '0;
            test_mem_addr         <= '0;
            even_addra            <= '0;
            even_addrb            <= '0;
            odd_addra             <= '0;
            odd_addrb             <= '0;
            even_mem_write_enable <= 1'b0;
            odd_mem_write_enable  <= 1'b0;
            result_sel            <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        n_len_q       <= temp_len;
                        m_len_q       <= test_len;
                        i_q           <= i_d;
                        j_q           <= j_d;
                        state_q       <= S_ISSUE;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        result_sel    <= 1'b0;
                        dtw_state     <= type_d;
                        temp_mem_addr <= i_d;
                        test_mem_addr <= j_d;
                        // Both row memories see j on port a and j-1 on port b:
                        // current row (write/left), previous row (up/diag).
                        even_addra    <= j_d;
                        even_addrb    <= jm1_d;
                        odd_addra     <= j_d;
                        odd_addrb     <= jm1_d;
                    end
                end

                S_ISSUE: begin
                    state_q <= S_WAIT;
                    wait_q  <= WAIT_LOAD;
                end

                S_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= S_WRITE;
                        if (i_q[0]) begin
                            odd_mem_write_enable  <= 1'b1;
                        end else begin
                            even_mem_write_enable <= 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end

                S_WRITE: begin
                    even_mem_write_enable <= 1'b0;
                    odd_mem_write_enable  <= 1'b0;
                    if (last_cell_d) begin
                        state_q       <= S_DONE;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        dtw_state     <= CT_DONE;
                        temp_mem_addr <= '0;
                        test_mem_addr <= '0;
                        result_sel    <= n_len_q[0];
                        // Only the final-row memory's port a points at M-1 so
                        // the result can be read out.
                        even_addra    <= n_len_q[0] ? '0 : m_len_q;
                        even_addrb    <= '0;
                        odd_addra     <= n_len_q[0] ? m_len_q : '0;
                        odd_addrb     <= '0;
                    end else begin
                        i_q           <= i_d;
                        j_q           <= j_d;
                        state_q       <= S_ISSUE;
                        dtw_state     <= type_d;
                        temp_mem_addr <= i_d;
                        test_mem_addr <= j_d;
                        even_addra    <= j_d;
                        even_addrb    <= jm1_d;
                        odd_addra     <= j_d;
                        odd_addrb     <= jm1_d;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtw_cell_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for dtw_cell_sequencer. A per-cycle expected trace is built from the
// matrix-walk rules (cell loops, cell period PIPE_LAT+1, final DONE vector) and
// compared against the DUT outputs one cycle at a time.
// -----------------------------------------------------------------------------
module tb_dtw_cell_sequencer;

  localparam int P  = 3;
  localparam int AW = 8;
  localparam int VW = 57;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [AW-1:0] temp_len;
  logic [AW-1:0] test_len;
  logic          busy;
  logic          done;
  logic [3:0]    dtw_state;
  logic [AW-1:0] temp_mem_addr;
  logic [AW-1:0] test_mem_addr;
  logic [AW-1:0] even_addra;
  logic [AW-1:0] even_addrb;
  logic [AW-1:0] odd_addra;
  logic [AW-1:0] odd_addrb;
  logic          even_mem_write_enable;
  logic          odd_mem_write_enable;
  logic          result_sel;
  logic [2:0]    fsm_state_o;

  int total;
  int bad;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] got;
  logic [VW-1:0] zero_vec;

  dtw_cell_sequencer #(.PIPE_LAT(P), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .temp_len(temp_len), .test_len(test_len),
    .busy(busy), .done(done), .dtw_state(dtw_state),
    .temp_mem_addr(temp_mem_addr), .test_mem_addr(test_mem_addr),
    .even_addra(even_addra), .even_addrb(even_addrb),
    .odd_addra(odd_addra), .odd_addrb(odd_addrb),
    .even_mem_write_enable(even_mem_write_enable),
    .odd_mem_write_enable(odd_mem_write_enable),
    .result_sel(result_sel), .fsm_state_o(fsm_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {busy, done, dtw_state, temp_mem_addr, test_mem_addr,
                even_addra, even_addrb, odd_addra, odd_addrb,
                even_mem_write_enable, odd_mem_write_enable, result_sel};

  function automatic logic [VW-1:0] mk(input int b, input int d, input int st,
                                       input int ti, input int tj,
                                       input int ea, input int eb,
                                       input int oa, input int ob,
                                       input int ewe, input int owe,
                                       input int rs);
    mk = {1'(b), 1'(d), 4'(st), 8'(ti), 8'(tj), 8'(ea), 8'(eb), 8'(oa),
          8'(ob), 1'(ewe), 1'(owe), 1'(rs)};
  endfunction

  // Reference trace: every cell occupies P+1 cycles with its write on the last,
  // followed by a single DONE vector.
  task automatic build_model(input int tl, input int ml);
    int typ;
    int jm;
    exp_q.delete();
    for (int i = 0; i <= tl; i++) begin
      for (int j = 0; j <= ml; j++) begin
        if (i == 0 && j == 0) typ = 1;
        else if (i == 0) typ = 2;
        else if (j == 0) typ = 3;
        else typ = 4;
        jm = (j == 0) ? 0 : j - 1;
        for (int c = 0; c <= P; c++) begin
          exp_q.push_back(mk(1, 0, typ, i, j, j, jm, j, jm,
                             (c == P && i % 2 == 0) ? 1 : 0,
                             (c == P && i % 2 == 1) ? 1 : 0, 0));
        end
      end
    end
    exp_q.push_back(mk(0, 1, 9, 0, 0, (tl % 2 == 0) ? ml : 0, 0,
                       (tl % 2 == 1) ? ml : 0, 0, 0, 0, tl % 2));
  endtask

  // driver: launch a run and check every cycle through the first DONE cycle.
  // With noise, start pulses and length changes are injected mid-run.
  task automatic run_check(input string name, input int tl, input int ml,
                           input bit noise);
    logic [VW-1:0] e;
    int n;
    int wr_even;
    int wr_odd;
    build_model(tl, ml);
    n = exp_q.size();
    wr_even = 0;
    wr_odd = 0;
    temp_len = 8'(tl);
    test_len = 8'(ml);
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k + 1, got, e);
      end
      wr_even += int'(even_mem_write_enable);
      wr_odd  += int'(odd_mem_write_enable);
      start = 1'b0;
      if (noise && k < n - 1) begin
        start = 1'($urandom_range(0, 1));
        temp_len = 8'($urandom);
        test_len = 8'($urandom);
      end
    end
    start = 1'b0;
    total++;
    if (wr_even !== ((tl + 2) / 2) * (ml + 1)) begin
      bad++;
      $display("FAIL %s even_writes: got %0d expected %0d", name, wr_even,
               ((tl + 2) / 2) * (ml + 1));
    end
    total++;
    if (wr_odd !== ((tl + 1) / 2) * (ml + 1)) begin
      bad++;
      $display("FAIL %s odd_writes: got %0d expected %0d", name, wr_odd,
               ((tl + 1) / 2) * (ml + 1));
    end
  endtask

  task automatic hold_done(input string name, input int tl, input int ml,
                           input int cycles);
    logic [VW-1:0] e;
    e = mk(0, 1, 9, 0, 0, (tl % 2 == 0) ? ml : 0, 0, (tl % 2 == 1) ? ml : 0,
           0, 0, 0, tl % 2);
    for (int k = 0; k < cycles; k++) begin
      temp_len = 8'($urandom);
      test_len = 8'($urandom);
      @(posedge clk);
      #1;
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s hold %0d: got %h expected %h", name, k, got, e);
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (got !== zero_vec) begin
        bad++;
        $display("FAIL %s idle %0d: got %h expected %h", name, k, got, zero_vec);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    temp_len = '0;
    test_len = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (got !== zero_vec || fsm_state_o !== 3'd0) begin
      bad++;
      $display("FAIL reset: got %h/%0d expected %h/0", got, fsm_state_o, zero_vec);
    end
    @(negedge clk);
    rst = 1'b1;
    check_idle("reset_release", 3);
  endtask

  task automatic test_single_cell();
    run_check("one_by_one", 0, 0, 1'b0);
    hold_done("one_by_one", 0, 0, 3);
  endtask

  task automatic test_two_by_three();
    // Relaunch straight from DONE with new lengths.
    run_check("two_by_three", 1, 2, 1'b0);
    hold_done("two_by_three", 1, 2, 2);
  endtask

  task automatic test_random_runs();
    int tl;
    int ml;
    for (int r = 0; r < 6; r++) begin
      tl = $urandom_range(0, 7);
      ml = $urandom_range(0, 7);
      run_check("random_noise", tl, ml, 1'b1);
      hold_done("random_noise", tl, ml, $urandom_range(0, 3));
    end
  endtask

  task automatic test_boundaries();
    run_check("tall_256x1", 255, 0, 1'b0);
    run_check("wide_1x256", 0, 255, 1'b0);
    run_check("mid_20x30", 19, 29, 1'b1);
  endtask

  task automatic test_abort();
    logic [VW-1:0] e;
    build_model(3, 3);
    temp_len = 8'd3;
    test_len = 8'd3;
    start = 1'b1;
    // Cycles 1..7: cell (0,0) and issue/wait of cell (0,1).
    for (int k = 0; k < 2 * (P + 1) - 1; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL abort_pre cycle %0d: got %h expected %h", k + 1, got, e);
      end
    end
    // Abort sampled on the edge that would enter WRITE of cell (0,1);
    // start is also high to show abort wins.
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    total++;
    if (got !== zero_vec) begin
      bad++;
      $display("FAIL abort_write_suppressed: got %h expected %h", got, zero_vec);
    end
    check_idle("abort_after", 3);
    run_check("after_abort", 3, 3, 1'b0);
    // Abort from DONE.
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    total++;
    if (got !== zero_vec) begin
      bad++;
      $display("FAIL abort_from_done: got %h expected %h", got, zero_vec);
    end
  endtask

  task automatic test_async_reset();
    temp_len = 8'd2;
    test_len = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL async_pre_busy: got %b expected 1", busy);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (got !== zero_vec) begin
      bad++;
      $display("FAIL async_reset_immediate: got %h expected %h", got, zero_vec);
    end
    @(negedge clk);
    rst = 1'b1;
    check_idle("async_release", 4);
    run_check("after_async", 2, 2, 1'b0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    zero_vec = '0;
    test_reset();
    test_single_cell();
    test_two_by_three();
    test_random_runs();
    test_boundaries();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
